score_collector: RTL and testbench

SCORE_COLLECTOR -- requirements
Module: score_collector

---
 rtl/nn_pkg.sv | 32 +++
 rtl/fp32_gt.sv | 14 +
 rtl/score_collector.sv | 141 ++++++++++++++
 tb/tb_score_collector.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the classifier output path.
//   NUM_CLASSES   number of class scores in one frame
//   float32_t     raw IEEE-754 single-precision word
//   state_t       collector FSM states (IDLE, FILL, FULL)
//   fp32_greater  team float order: larger biased exponent wins, then the
//                 larger {1, mantissa}; the sign bit is ignored.
package nn_pkg;

   localparam int NUM_CLASSES = 10;

   typedef logic [31:0] float32_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } state_t;

   function automatic logic fp32_greater(input float32_t a, input float32_t b);
      logic [7:0]  w_exp_a;
      logic [7:0]  w_exp_b;
      logic [23:0] w_man_a;
      logic [23:0] w_man_b;
      w_exp_a = a[30:23];
      w_exp_b = b[30:23];
      w_man_a = {1'b1, a[22:0]};
      w_man_b = {1'b1, b[22:0]};
      if (w_exp_a != w_exp_b) return (w_exp_a > w_exp_b);
      return (w_man_a > w_man_b);
   endfunction

endpackage

// File: rtl/fp32_gt.sv
// fp32_gt: combinational comparator in the team float order.
//   a, b     float32 operands
//   a_gt_b   1 when a is strictly greater than b (sign ignored)
module fp32_gt
   import nn_pkg::*;
(
   input  float32_t a,
   input  float32_t b,
   output logic     a_gt_b
);

   assign a_gt_b = fp32_greater(a, b);

endmodule

// File: rtl/score_collector.sv
// score_collector: gathers NUM_CLASSES float32 scores into one frame and
// holds the completed frame until the consumer acknowledges it.
//   Clk, Reset_n           clock, asynchronous active-low reset
//   in_valid/in_ready      score input handshake, in_score data, in_last frame end
//   clear                  synchronous abort of the current frame
//   scores[]               collected vector, index 0 first
//   out_valid/out_ack      held-frame handshake
//   count                  scores accepted in the current frame (0..10)
//   frame_err              one-cycle pulse on a framing error
//   best_idx               index of the maximum score; constant 0 unless
//                          SCORE_COLLECTOR_RUNNING_MAX_EN is defined
//   dbg_state              current FSM state
//
// Handshake: a score transfers on a rising Clk edge where in_valid and
// in_ready are both 1; in_ready depends only on the registered state, and
// out_valid stays high with scores stable until out_ack is sampled.
module score_collector
   import nn_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  float32_t   in_score,
   input  logic       in_last,
   input  logic       clear,
   output float32_t   scores [NUM_CLASSES],
   output logic       out_valid,
   input  logic       out_ack,
   output logic [3:0] count,
   output logic       frame_err,
   output logic [3:0] best_idx,
   output state_t     dbg_state
);

   state_t     r_state;
   logic [3:0] r_count;
   logic       r_out_valid;
   logic       r_frame_err;
   float32_t   r_scores [NUM_CLASSES];

   logic w_xfer;
   logic w_tenth;
   logic w_bad_frame;

   assign in_ready = (r_state != FULL);
   assign w_xfer   = in_valid && in_ready && !clear;
   assign w_tenth  = (r_count == 4'(NUM_CLASSES - 1));
   // in_last must coincide exactly with the tenth score: early last or a
   // missing last are both framing errors.
   assign w_bad_frame = in_last ^ w_tenth;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_frame_err <= 1'b0;
         for (int i = 0; i < NUM_CLASSES; i++) r_scores[i] <= '0;
      end else begin
         r_frame_err <= 1'b0;
         if (clear) begin
            // Abort wins over transfer and ack; scores keep their values.
            r_state     <= IDLE;
            r_count     <= '0;
            r_out_valid <= 1'b0;
         end else begin
            case (r_state)
               IDLE, FILL: begin
                  if (in_valid) begin
                     for (int i = 0; i < NUM_CLASSES; i++)
                        if (r_count == 4'(i)) r_scores[i] <= in_score;
                     if (w_bad_frame) begin
                        r_state     <= IDLE;
                        r_count     <= '0;
                        r_frame_err <= 1'b1;
                     end else if (w_tenth) begin
                        r_state     <= FULL;
                        r_count     <= r_count + 4'd1;
                        r_out_valid <= 1'b1;
                     end else begin
                        r_state <= FILL;
                        r_count <= r_count + 4'd1;
                     end
                  end
               end
               FULL: begin
                  if (out_ack) begin
                     r_state     <= IDLE;
                     r_count     <= '0;
                     r_out_valid <= 1'b0;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

`ifdef SCORE_COLLECTOR_RUNNING_MAX_EN
   float32_t   r_best_val;
   logic [3:0] r_best_idx;
   logic       w_gt;

   fp32_gt u_fp32_gt (
      .a      (in_score),
      .b      (r_best_val),
      .a_gt_b (w_gt)
   );

   // First score of a frame loads unconditionally; later scores replace
   // only on strictly greater so ties keep the lowest index.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_best_val <= '0;
         r_best_idx <= '0;
      end else if (w_xfer) begin
         if (r_count == 4'd0) begin
            r_best_val <= in_score;
            r_best_idx <= '0;
         end else if (w_gt) begin
            r_best_val <= in_score;
            r_best_idx <= r_count;
         end
      end
   end

   assign best_idx = r_best_idx;
`else
   logic w_unused_xfer;
   assign w_unused_xfer = w_xfer;
   assign best_idx      = '0;
`endif

   assign scores    = r_scores;
   assign out_valid = r_out_valid;
   assign count     = r_count;
   assign frame_err = r_frame_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_score_collector.sv
module tb_score_collector;
   import nn_pkg::*;

   logic       Clk;
   logic       Reset_n;
   logic       in_valid;
   logic       in_ready;
   float32_t   in_score;
   logic       in_last;
   logic       clear;
   float32_t   scores [NUM_CLASSES];
   logic       out_valid;
   logic       out_ack;
   logic [3:0] count;
   logic       frame_err;
   logic [3:0] best_idx;
   state_t     dbg_state;

   int n_checks;
   int n_errors;
   float32_t frame_v [NUM_CLASSES];
   float32_t snap_v  [NUM_CLASSES];

   score_collector dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_score  (in_score),
      .in_last   (in_last),
      .clear     (clear),
      .scores    (scores),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .count     (count),
      .frame_err (frame_err),
      .best_idx  (best_idx),
      .dbg_state (dbg_state)
   );

   // clock: posedges at 5, 15, 25, ...
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // one score offered for one cycle; outputs sampled 1 time unit after the edge
   task automatic xfer(input float32_t s, input logic last);
      in_valid = 1'b1;
      in_score = s;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input int n, input int last_at);
      for (int i = 0; i < n; i++) xfer(frame_v[i], (i == last_at));
   endtask

   task automatic check_best(input string tag, input logic [3:0] exp_on);
`ifdef SCORE_COLLECTOR_RUNNING_MAX_EN
      check(tag, 32'(best_idx), 32'(exp_on));
`else
      check(tag, 32'(best_idx), 32'd0);
`endif
   endtask

   task automatic ack_frame();
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      Reset_n  = 1'b0;
      in_valid = 1'b0;
      in_score = '0;
      in_last  = 1'b0;
      clear    = 1'b0;
      out_ack  = 1'b0;

      // reset state
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_count",     32'(count),     32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_best_idx",  32'(best_idx),  32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_state",     32'(dbg_state), 32'(IDLE));
      check("rst_score0",    scores[0],      32'h0);
      Reset_n = 1'b1;
      tick();

      // nominal frame: 3F800000 + i, last on i = 9
      for (int i = 0; i < NUM_CLASSES; i++) frame_v[i] = 32'h3F800000 + 32'(i);
      send_frame(9, 9);
      check("nom_count9",    32'(count),     32'd9);
      check("nom_ready9",    32'(in_ready),  32'd1);
      check("nom_valid9",    32'(out_valid), 32'd0);
      xfer(frame_v[9], 1'b1);
      check("nom_out_valid", 32'(out_valid), 32'd1);
      check("nom_count",     32'(count),     32'd10);
      check("nom_in_ready",  32'(in_ready),  32'd0);
      for (int i = 0; i < NUM_CLASSES; i++)
         check($sformatf("nom_score%0d", i), scores[i], 32'h3F800000 + 32'(i));
      check_best("nom_best_idx", 4'd9);

      // backpressure: held 20 cycles while a producer keeps offering
      in_valid = 1'b1;
      in_score = 32'hDEADBEEF;
      for (int c = 0; c < 20; c++) begin
         tick();
         check("bp_in_ready",  32'(in_ready),  32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
      end
      check("bp_count", 32'(count), 32'd10);
      for (int i = 0; i < NUM_CLASSES; i++)
         check($sformatf("bp_score%0d", i), scores[i], 32'h3F800000 + 32'(i));
      // ack cycle must not accept the offered score
      ack_frame();
      in_valid = 1'b0;
      check("ack_out_valid", 32'(out_valid), 32'd0);
      check("ack_count",     32'(count),     32'd0);
      check("ack_in_ready",  32'(in_ready),  32'd1);
      check("ack_state",     32'(dbg_state), 32'(IDLE));

      // early last on 4th transfer, out_ack during FILL is ignored
      for (int i = 0; i < NUM_CLASSES; i++) frame_v[i] = 32'h40000000 + 32'(i);
      xfer(frame_v[0], 1'b0);
      out_ack = 1'b1;
      xfer(frame_v[1], 1'b0);
      out_ack = 1'b0;
      xfer(frame_v[2], 1'b0);
      check("early_count3", 32'(count), 32'd3);
      xfer(frame_v[3], 1'b1);
      check("early_err",       32'(frame_err), 32'd1);
      check("early_count",     32'(count),     32'd0);
      check("early_out_valid", 32'(out_valid), 32'd0);
      tick();
      check("early_err_pulse", 32'(frame_err), 32'd0);
      check("early_out_valid2",32'(out_valid), 32'd0);

      // missing last on the 10th transfer
      send_frame(10, 99);
      check("nolast_err",       32'(frame_err), 32'd1);
      check("nolast_count",     32'(count),     32'd0);
      check("nolast_out_valid", 32'(out_valid), 32'd0);
      tick();
      check("nolast_err_pulse", 32'(frame_err), 32'd0);

      // tie: scores[2] = scores[7] = 3.0, others 0.5
      for (int i = 0; i < NUM_CLASSES; i++) frame_v[i] = 32'h3F000000;
      frame_v[2] = 32'h40400000;
      frame_v[7] = 32'h40400000;
      send_frame(10, 9);
      check("tie_out_valid", 32'(out_valid), 32'd1);
      check("tie_score7",    scores[7],      32'h40400000);
      check_best("tie_best_idx", 4'd2);
      ack_frame();

      // exponent beats mantissa, sign ignored: -8.0 at 3 beats 7.99 at 5
      for (int i = 0; i < NUM_CLASSES; i++) frame_v[i] = 32'h3F800000;
      frame_v[3] = 32'hC1000000;
      frame_v[5] = 32'h40FFFFFF;
      send_frame(10, 9);
      check("ord_out_valid", 32'(out_valid), 32'd1);
      check_best("ord_best_idx", 4'd3);
      ack_frame();

      // clear together with the 10th transfer
      for (int i = 0; i < NUM_CLASSES; i++) frame_v[i] = 32'h41000000 + 32'(i);
      send_frame(9, 99);
      clear = 1'b1;
      xfer(frame_v[9], 1'b1);
      clear = 1'b0;
      check("clr_out_valid", 32'(out_valid), 32'd0);
      check("clr_frame_err", 32'(frame_err), 32'd0);
      check("clr_count",     32'(count),     32'd0);
      check("clr_in_ready",  32'(in_ready),  32'd1);
      check("clr_score0",    scores[0],      32'h41000000);
      check("clr_score9",    scores[9],      32'h3F800000);
      tick();
      check("clr_out_valid2", 32'(out_valid), 32'd0);
      check("clr_frame_err2", 32'(frame_err), 32'd0);

      // asynchronous reset while FULL
      for (int i = 0; i < NUM_CLASSES; i++) frame_v[i] = 32'h3F800000 + 32'(i);
      send_frame(10, 9);
      check("ar_out_valid_pre", 32'(out_valid), 32'd1);
      #2;
      Reset_n = 1'b0;
      #1;
      check("ar_out_valid", 32'(out_valid), 32'd0);
      check("ar_count",     32'(count),     32'd0);
      check("ar_frame_err", 32'(frame_err), 32'd0);
      check("ar_best_idx",  32'(best_idx),  32'd0);
      check("ar_in_ready",  32'(in_ready),  32'd1);
      for (int i = 0; i < NUM_CLASSES; i++)
         check($sformatf("ar_score%0d", i), scores[i], 32'h0);
      #3;
      Reset_n = 1'b1;
      tick();
      check("ar_frame_err_post", 32'(frame_err), 32'd0);
      check("ar_state_post",     32'(dbg_state), 32'(IDLE));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
